// File: rtl/frame_wr_scheduler.sv
// Frame-granular write scheduler: grants one of two frame sources per
// new-frame window and muxes its pixel stream into the memory write port.
// Ports: clk_50m/rst_n; new_frame_i, mem_rdy_to_wr in; mem_wr_req,
// mem_din out; auto_en, src1_req in; srcN_start/srcN_wr_en out;
// srcN_den/srcN_dout in; busy, grant, frame_cnt, skip_cnt and the
// sticky overrun/timeout_err/proto_err status out.
module frame_wr_scheduler #(
  parameter int DATA_DEPTH = 1024*768,
  parameter int CNT_W      = 20,
  parameter int TIMEOUT    = 65535,
  parameter int TO_W       = 16
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        new_frame_i,
  input  logic        mem_rdy_to_wr,
  output logic        mem_wr_req,
  output logic [15:0] mem_din,
  input  logic        auto_en,
  input  logic        src1_req,
  output logic        src0_start,
  output logic        src1_start,
  output logic        src0_wr_en,
  output logic        src1_wr_en,
  input  logic        src0_den,
  input  logic [15:0] src0_dout,
  input  logic        src1_den,
  input  logic [15:0] src1_dout,
  output logic        busy,
  output logic        grant,
  output logic [15:0] frame_cnt,
  output logic [15:0] skip_cnt,
  output logic        overrun,
  output logic        timeout_err,
  output logic        proto_err
);

  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(DATA_DEPTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] pix_nxt;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_nxt;
  logic             pend;
  logic             pend_clr;
  logic             grant_nxt;
  logic [15:0]      frame_nxt;
  logic [15:0]      skip_nxt;
  logic             tout_nxt;
  logic             gden;
  logic             ngden;
  logic [15:0]      gdout;
  logic             acc;
  logic             pick_ok;
  logic             pick;

  assign gden  = grant ? src1_den  : src0_den;
  assign ngden = grant ? src0_den  : src1_den;
  assign gdout = grant ? src1_dout : src0_dout;
  assign acc   = gden & mem_rdy_to_wr;
  assign busy  = (state != IDLE);

  // Round-robin only matters when both sources are eligible.
  assign pick_ok = auto_en | pend;
  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      (auto_en & pend):  pick = ~grant;
      (~auto_en & pend): pick = 1'b1;
      default:           pick = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    pix_nxt    = pix_cnt;
    to_nxt     = to_cnt;
    grant_nxt  = grant;
    frame_nxt  = frame_cnt;
    skip_nxt   = skip_cnt;
    tout_nxt   = timeout_err;
    pend_clr   = 1'b0;
    src0_start = 1'b0;
    src1_start = 1'b0;
    src0_wr_en = 1'b0;
    src1_wr_en = 1'b0;
    mem_wr_req = 1'b0;
    mem_din    = '0;
    unique case (state)
      IDLE: begin
        if (new_frame_i) begin
          if (pick_ok) begin
            grant_nxt = pick;
            pend_clr  = pick;
            state_nxt = START;
          end else if (skip_cnt != 16'hFFFF) begin
            skip_nxt = skip_cnt + 16'd1;
          end
        end
      end
      START: begin
        src0_start = ~grant;
        src1_start = grant;
        pix_nxt    = '0;
        to_nxt     = '0;
        state_nxt  = RUN;
      end
      RUN: begin
        src0_wr_en = ~grant & mem_rdy_to_wr;
        src1_wr_en = grant & mem_rdy_to_wr;
        mem_wr_req = acc;
        mem_din    = gdout;
        if (acc) begin
          pix_nxt = pix_cnt + 1'b1;
          to_nxt  = '0;
          if (pix_cnt == PIX_LAST) begin
            state_nxt = DONE;
          end
        end else if (mem_rdy_to_wr) begin
          // Only source-side starvation counts toward the timeout.
          if (to_cnt == TO_LAST) begin
            tout_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            to_nxt = to_cnt + 1'b1;
          end
        end
      end
      DONE: begin
        frame_nxt = frame_cnt + 16'd1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      to_cnt      <= '0;
      pend        <= 1'b0;
      grant       <= 1'b0;
      frame_cnt   <= '0;
      skip_cnt    <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pix_cnt     <= pix_nxt;
      to_cnt      <= to_nxt;
      pend        <= src1_req | (pend & ~pend_clr);
      grant       <= grant_nxt;
      frame_cnt   <= frame_nxt;
      skip_cnt    <= skip_nxt;
      timeout_err <= tout_nxt;
      if (new_frame_i && state != IDLE) begin
        overrun <= 1'b1;
      end
      // Granted data is only legal while streaming.
      if (ngden || (gden && state != RUN)) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/frame_wr_scheduler.md
Name: frame_wr_scheduler

Overview:
- Frame-granular write scheduler in the clk_50m domain, between the frame-write requesters and the memory arbiter's single write port.
- Two requesters share the port:
  - src0: pattern generator, auto mode.
  - src1: host/loader, on request.
- On each new-frame grant window it selects one source, issues that source a start pulse, and muxes its pixel stream into the write port.
- It counts the frame to completion and flags overruns, timeouts and protocol errors.

Parameters:
- DATA_DEPTH, 1024*768, pixels (16-bit words) per frame.
- CNT_W, 20, pixel counter width; must satisfy 2^CNT_W >= DATA_DEPTH.
- TIMEOUT, 65535, max idle cycles inside a frame before abort.
- TO_W, 16, timeout counter width.

Ports:
- clk_50m, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- new_frame_i, in, 1, single-cycle pulse from the memory arbiter: write side may start a frame.
- mem_rdy_to_wr, in, 1, memory write port can accept data this cycle.
- mem_wr_req, out, 1, write strobe to the memory port.
- mem_din, out, 16, write data to the memory port.
- auto_en, in, 1, src0 is eligible for grants.
- src1_req, in, 1, pulse: src1 requests one frame.
- src0_start, out, 1, one-cycle start pulse to src0.
- src1_start, out, 1, one-cycle start pulse to src1.
- src0_wr_en, out, 1, write enable to src0.
- src1_wr_en, out, 1, write enable to src1.
- src0_den, in, 1, src0 data valid.
- src0_dout, in, 16, src0 data.
- src1_den, in, 1, src1 data valid.
- src1_dout, in, 16, src1 data.
- busy, out, 1, a frame is in progress.
- grant, out, 1, currently/last granted source (0/1).
- frame_cnt, out, 16, completed frames, wraps at 0xFFFF.
- skip_cnt, out, 16, new_frame pulses with no eligible source, saturating.
- overrun, out, 1, sticky: new_frame_i arrived while busy.
- timeout_err, out, 1, sticky: frame aborted on timeout.
- proto_err, out, 1, sticky: non-granted source asserted den.

Behaviour:
- Reset (async, rst_n low): state IDLE; counters 0; busy=0; grant=0; start pulses 0; sticky flags 0; src1 pending latch 0. A reset mid-frame abandons the frame; there is no resume.
- src1 pending latch:
  - Set on src1_req.
  - Cleared in the cycle src1 is granted.
  - src1_req in the same cycle as the clear keeps the latch set, so one request is queued.
- States: IDLE, START, RUN, DONE.
- IDLE, on new_frame_i, picks a candidate:
  - Both eligible (pending and auto_en): round-robin, so the source not granted last wins.
  - Only one eligible: that source.
  - Neither eligible: skip_cnt+1 and stay in IDLE.
  - When a source is picked: register grant, go to START.
- START (1 cycle):
  - Assert src<grant>_start for exactly one cycle.
  - Clear pix_cnt and to_cnt; busy=1; go to RUN.
  - busy stays 1 from START through DONE.
- RUN:
  - src<grant>_wr_en = mem_rdy_to_wr; non-granted wr_en = 0. Combinational, zero latency.
  - mem_wr_req = src<grant>_den & mem_rdy_to_wr.
  - mem_din = src<grant>_dout, zero latency. mem_din = 0 outside RUN; mem_wr_req = 0 outside RUN.
  - Each accepted word: pix_cnt+1 and to_cnt cleared.
  - Accepted word with pix_cnt == DATA_DEPTH-1: go to DONE.
  - No accepted word: to_cnt+1. Stalls caused by mem_rdy_to_wr=0 do not count toward timeout.
  - to_cnt reaching TIMEOUT: set timeout_err, go to IDLE without incrementing frame_cnt.
- DONE (1 cycle): frame_cnt+1; busy=0; go to IDLE.
- new_frame_i in START, RUN or DONE: ignored, sets overrun. new_frame_i in IDLE in the same cycle DONE exits is not possible because DONE lasts one cycle; in the cycle after DONE a pulse is accepted normally.
- Non-granted source den=1 at any time, or either den=1 in IDLE: data dropped, proto_err set.
- Granted-source den above DATA_DEPTH is impossible because the state leaves RUN on the last word. Extra den pulses arriving in DONE/IDLE set proto_err.
- auto_en deasserted mid-frame: the frame completes and only future grants are affected.

Test Plan:
- Reset, then auto_en=1, new_frame pulse, src0 streams 4 words (DATA_DEPTH=4) with mem_rdy_to_wr=1 -> src0_start one cycle after pulse; 4 mem_wr_req with matching mem_din; busy falls; frame_cnt=1.
- auto_en=1, src1_req pulsed, 3 new_frame windows -> grants alternate 1,0,1 only while src1 is pending; with src1 re-requested each frame, grants are 1,0,1; src1 latch cleared after each grant.
- auto_en=0, no src1_req, 3 new_frame pulses -> no start pulses, skip_cnt=3, busy stays 0.
- mem_rdy_to_wr toggled 50% during RUN -> src0_wr_en mirrors it; no write while low; 4 accepted words; no timeout.
- TIMEOUT=8, src0 stops after 2 words with mem_rdy_to_wr=1 -> timeout_err set 8 cycles after last word; state IDLE; frame_cnt unchanged.
- new_frame during RUN plus src1_den=1 while src0 granted -> overrun=1, proto_err=1, src1 data absent from mem_din; frame completes normally.
